// File: rtl/smoldvi_rx_word_align.sv
// Word aligner for one DDR-sampled TMDS lane: hunts for control tokens to find the
// 10-bit symbol boundary and emits one aligned symbol every fifth clk_x5 cycle.
module smoldvi_rx_word_align #(
    parameter int CTRL_RUN     = 4,
    parameter int SEARCH_WORDS = 64,
    parameter int LOSS_WORDS   = 4096
) (
    input  logic       clk_x5,
    input  logic       rst_n_x5,
    input  logic       d_rise,
    input  logic       d_fall,
    input  logic       resync,
    output logic [9:0] word_out,
    output logic       word_valid,
    output logic       is_ctrl,
    output logic       locked,
    output logic [3:0] bit_offset
);
    localparam int RUN_W  = $clog2(CTRL_RUN + 1);
    localparam int SRCH_W = $clog2(SEARCH_WORDS + 1);
    localparam int LOSS_W = $clog2(LOSS_WORDS + 1);

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    state_t            state, state_nx;
    logic [19:0]       sr_p0;
    logic [2:0]        phase_p0;
    logic              eval_p0;
    logic [9:0]        cand_p0;
    logic              match_p0;
    logic [9:0]        word_p1;
    logic              ctrl_p1;
    logic              vld_p1;
    logic [RUN_W-1:0]  run_ctr, run_nx, run_cnt;
    logic [SRCH_W-1:0] srch_ctr, srch_nx, srch_cnt;
    logic [LOSS_W-1:0] loss_ctr, loss_nx, loss_cnt;
    logic [3:0]        off_nx;

    function automatic logic is_token(input logic [9:0] w);
        return (w == 10'b1101010100) || (w == 10'b0010101011) ||
               (w == 10'b0101010100) || (w == 10'b1010101011);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [15:0] lim);
        return (v >= lim) ? lim : v + 16'd1;
    endfunction

    function automatic logic [3:0] slip(input logic [3:0] o);
        return (o == 4'd9) ? 4'd0 : o + 4'd1;
    endfunction

    // Stage 0: 20-bit sample history and free-running word phase
    always_ff @(posedge clk_x5 or negedge rst_n_x5) begin
        if (!rst_n_x5) begin
            sr_p0    <= '0;
            phase_p0 <= '0;
        end else begin
            sr_p0    <= {d_fall, d_rise, sr_p0[19:2]};
            phase_p0 <= (phase_p0 == 3'd4) ? 3'd0 : phase_p0 + 3'd1;
        end
    end

    assign eval_p0 = (phase_p0 == 3'd4);

    always_comb begin
        cand_p0 = sr_p0[9:0];
        for (int i = 1; i < 10; i++) begin
            if (bit_offset == 4'(i)) cand_p0 = sr_p0[i +: 10];
        end
    end

    assign match_p0 = is_token(cand_p0);

    // Stage 1: captured symbol, token flag and strobe
    always_ff @(posedge clk_x5 or negedge rst_n_x5) begin
        if (!rst_n_x5) begin
            word_p1 <= '0;
            ctrl_p1 <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= eval_p0;
            if (eval_p0) begin
                word_p1 <= cand_p0;
                ctrl_p1 <= match_p0;
            end
        end
    end

    assign word_out   = word_p1;
    assign is_ctrl    = ctrl_p1;
    assign word_valid = vld_p1;

    always_ff @(posedge clk_x5 or negedge rst_n_x5) begin
        if (!rst_n_x5) begin
            state      <= SEARCH;
            bit_offset <= '0;
            run_ctr    <= '0;
            srch_ctr   <= '0;
            loss_ctr   <= '0;
        end else begin
            state      <= state_nx;
            bit_offset <= off_nx;
            run_ctr    <= run_nx;
            srch_ctr   <= srch_nx;
            loss_ctr   <= loss_nx;
        end
    end

    // resync outranks the word evaluation that may land in the same cycle
    always_comb begin
        state_nx = state;
        off_nx   = bit_offset;
        run_nx   = run_ctr;
        srch_nx  = srch_ctr;
        loss_nx  = loss_ctr;
        run_cnt  = '0;
        srch_cnt = '0;
        loss_cnt = '0;
        if (resync) begin
            state_nx = SEARCH;
            off_nx   = slip(bit_offset);
            run_nx   = '0;
            srch_nx  = '0;
            loss_nx  = '0;
        end else if (eval_p0) begin
            case (state)
                SEARCH: begin
                    run_cnt  = match_p0 ? RUN_W'(sat_inc(16'(run_ctr), 16'(CTRL_RUN))) : '0;
                    srch_cnt = SRCH_W'(sat_inc(16'(srch_ctr), 16'(SEARCH_WORDS)));
                    if (run_cnt == RUN_W'(CTRL_RUN)) begin
                        state_nx = LOCKED;
                        run_nx   = '0;
                        srch_nx  = '0;
                        loss_nx  = '0;
                    end else if (srch_cnt == SRCH_W'(SEARCH_WORDS)) begin
                        off_nx  = slip(bit_offset);
                        run_nx  = '0;
                        srch_nx = '0;
                    end else begin
                        run_nx  = run_cnt;
                        srch_nx = srch_cnt;
                    end
                end
                LOCKED: begin
                    loss_cnt = match_p0 ? '0 : LOSS_W'(sat_inc(16'(loss_ctr), 16'(LOSS_WORDS)));
                    if (loss_cnt == LOSS_W'(LOSS_WORDS)) begin
                        state_nx = SEARCH;
                        off_nx   = slip(bit_offset);
                        run_nx   = '0;
                        srch_nx  = '0;
                        loss_nx  = '0;
                    end else begin
                        loss_nx = loss_cnt;
                    end
                end
                default: state_nx = SEARCH;
            endcase
        end
    end

    always_comb begin
        locked = (state == LOCKED);
    end
endmodule
